// File: rtl/pm_seq_pkg.sv
// Shared constants for the power-domain sequencer: default delays and FSM state encodings.
package pm_seq_pkg;

    localparam int DEF_NUM_STAGES = 4;
    localparam int DEF_STAGE_DLY  = 8;
    localparam int DEF_ISO_DLY    = 2;

    typedef logic [3:0] state_t;

    // Retention states keep fixed codes even when the feature is compiled out.
    localparam state_t S_OFF      = 4'd0;
    localparam state_t S_PUP_SW   = 4'd1;
    localparam state_t S_PUP_WAIT = 4'd2;
    localparam state_t S_PUP_RET  = 4'd3;
    localparam state_t S_PUP_RST  = 4'd4;
    localparam state_t S_PUP_ISO  = 4'd5;
    localparam state_t S_ON       = 4'd6;
    localparam state_t S_PDN_ISO  = 4'd7;
    localparam state_t S_PDN_RET  = 4'd8;
    localparam state_t S_PDN_RST  = 4'd9;
    localparam state_t S_PDN_SW   = 4'd10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pm_seq_if.sv
// Controller-facing REQ/ACK handshake plus domain switch/isolation/reset controls.
// Adds the RET retention output when PM_SEQ_RETENTION_EN is defined.
interface pm_seq_if #(
    parameter int NUM_STAGES = 4
);
    logic                  req;
    logic                  sw_ack;
    logic                  ack;
    logic                  busy;
    logic [NUM_STAGES-1:0] sw_en;
    logic                  iso_n;
    logic                  dom_rst_n;
`ifdef PM_SEQ_RETENTION_EN
    logic                  ret;
`endif

    modport master (
`ifdef PM_SEQ_RETENTION_EN
        input  ret,
`endif
        output req, sw_ack,
        input  ack, busy, sw_en, iso_n, dom_rst_n
    );

    modport slave (
`ifdef PM_SEQ_RETENTION_EN
        output ret,
`endif
        input  req, sw_ack,
        output ack, busy, sw_en, iso_n, dom_rst_n
    );

endinterface

// File: rtl/pm_seq_delay_cnt.sv
// Loadable down-counter that parks at zero; expire flags the zero value.
module pm_seq_delay_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             expire
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign expire = (value == '0);

endmodule

// File: rtl/pm_power_sequencer.sv
// Staged power-up/down sequencer for one switchable domain with a four-phase REQ/ACK handshake.
// Define PM_SEQ_RETENTION_EN to add the retention output and its PUP_RET/PDN_RET states.
module pm_power_sequencer
    import pm_seq_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int STAGE_DLY  = DEF_STAGE_DLY,
    parameter int ISO_DLY    = DEF_ISO_DLY
) (
    input logic     clk,
    input logic     rst_n,
    pm_seq_if.slave bus
);

    localparam int CNT_W = $clog2(max_int(STAGE_DLY, ISO_DLY) + 1);
    localparam logic [CNT_W-1:0]      STG_LOAD = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0]      ISO_LOAD = CNT_W'(ISO_DLY - 1);
    localparam logic [NUM_STAGES-1:0] SW_FIRST = NUM_STAGES'(1);

    state_t                state, state_nxt;
    logic [NUM_STAGES-1:0] sw_en, sw_en_nxt;
    logic                  iso_n, iso_n_nxt;
    logic                  dom_rst_n, dom_rst_n_nxt;
    logic                  ack, ack_nxt;
    logic                  busy, busy_nxt;
    logic                  load;
    logic [CNT_W-1:0]      load_val;
    logic [CNT_W-1:0]      cnt_value_unused;
    logic                  expire;
`ifdef PM_SEQ_RETENTION_EN
    logic                  ret, ret_nxt;
`endif

    pm_seq_delay_cnt #(.CNT_W(CNT_W)) u_delay_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .value    (cnt_value_unused),
        .expire   (expire)
    );

    // REQ is only looked at in OFF/ON, so a toggle mid-sequence waits for completion.
    always_comb begin
        state_nxt     = state;
        sw_en_nxt     = sw_en;
        iso_n_nxt     = iso_n;
        dom_rst_n_nxt = dom_rst_n;
        ack_nxt       = ack;
        load          = 1'b0;
        load_val      = '0;
`ifdef PM_SEQ_RETENTION_EN
        ret_nxt       = ret;
`endif
        case (state)
            S_OFF: if (bus.req) begin
                state_nxt = S_PUP_SW;
                sw_en_nxt = SW_FIRST;
                load      = 1'b1;
                load_val  = STG_LOAD;
            end
            S_PUP_SW: if (expire) begin
                if (sw_en[NUM_STAGES-1]) begin
                    state_nxt = S_PUP_WAIT;
                end else begin
                    sw_en_nxt = (sw_en << 1) | SW_FIRST;
                    load      = 1'b1;
                    load_val  = STG_LOAD;
                end
            end
            S_PUP_WAIT: if (bus.sw_ack) begin
`ifdef PM_SEQ_RETENTION_EN
                state_nxt     = S_PUP_RET;
                ret_nxt       = 1'b0;
`else
                state_nxt     = S_PUP_RST;
                dom_rst_n_nxt = 1'b1;
`endif
                load          = 1'b1;
                load_val      = ISO_LOAD;
            end
`ifdef PM_SEQ_RETENTION_EN
            S_PUP_RET: if (expire) begin
                state_nxt     = S_PUP_RST;
                dom_rst_n_nxt = 1'b1;
                load          = 1'b1;
                load_val      = ISO_LOAD;
            end
`endif
            S_PUP_RST: if (expire) begin
                state_nxt = S_PUP_ISO;
                iso_n_nxt = 1'b1;
                load      = 1'b1;
                load_val  = ISO_LOAD;
            end
            S_PUP_ISO: if (expire) begin
                state_nxt = S_ON;
                ack_nxt   = 1'b1;
            end
            S_ON: if (!bus.req) begin
                state_nxt = S_PDN_ISO;
                iso_n_nxt = 1'b0;
                load      = 1'b1;
                load_val  = ISO_LOAD;
            end
            S_PDN_ISO: if (expire) begin
`ifdef PM_SEQ_RETENTION_EN
                state_nxt     = S_PDN_RET;
                ret_nxt       = 1'b1;
`else
                state_nxt     = S_PDN_RST;
                dom_rst_n_nxt = 1'b0;
`endif
                load          = 1'b1;
                load_val      = ISO_LOAD;
            end
`ifdef PM_SEQ_RETENTION_EN
            S_PDN_RET: if (expire) begin
                state_nxt     = S_PDN_RST;
                dom_rst_n_nxt = 1'b0;
                load          = 1'b1;
                load_val      = ISO_LOAD;
            end
`endif
            S_PDN_RST: if (expire) begin
                state_nxt = S_PDN_SW;
                load      = 1'b1;
                load_val  = STG_LOAD;
            end
            // Each stage is held a full STAGE_DLY before its switch drops, highest first.
            S_PDN_SW: if (expire) begin
                sw_en_nxt = sw_en >> 1;
                if (sw_en_nxt == '0) begin
                    state_nxt = S_OFF;
                    ack_nxt   = 1'b0;
                end else begin
                    load     = 1'b1;
                    load_val = STG_LOAD;
                end
            end
            default: state_nxt = S_OFF;
        endcase
        busy_nxt = (state_nxt != S_OFF) && (state_nxt != S_ON);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_OFF;
            sw_en     <= '0;
            iso_n     <= 1'b0;
            dom_rst_n <= 1'b0;
            ack       <= 1'b0;
            busy      <= 1'b0;
`ifdef PM_SEQ_RETENTION_EN
            ret       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            sw_en     <= sw_en_nxt;
            iso_n     <= iso_n_nxt;
            dom_rst_n <= dom_rst_n_nxt;
            ack       <= ack_nxt;
            busy      <= busy_nxt;
`ifdef PM_SEQ_RETENTION_EN
            ret       <= ret_nxt;
`endif
        end
    end

    assign bus.sw_en     = sw_en;
    assign bus.iso_n     = iso_n;
    assign bus.dom_rst_n = dom_rst_n;
    assign bus.ack       = ack;
    assign bus.busy      = busy;
`ifdef PM_SEQ_RETENTION_EN
    assign bus.ret       = ret;
`endif

endmodule

// File: tb/tb_pm_power_sequencer.sv
// Directed bench for pm_power_sequencer with default delays (4 stages, STAGE_DLY 8, ISO_DLY 2).
// Retention checks are compiled in when PM_SEQ_RETENTION_EN is defined.
module tb_pm_power_sequencer;

    localparam int NS = 4;
`ifdef PM_SEQ_RETENTION_EN
    localparam int X = 2;
`else
    localparam int X = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    pm_seq_if #(.NUM_STAGES(NS)) bus ();

    pm_power_sequencer #(
        .NUM_STAGES (NS),
        .STAGE_DLY  (8),
        .ISO_DLY    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic r, input logic a);
        bus.req    = r;
        bus.sw_ack = a;
    endtask

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Packed as {busy, ack, iso_n, dom_rst_n, sw_en}.
    task automatic check_output(input string tag, input logic [NS-1:0] sw, input logic iso,
                                input logic drst, input logic ak, input logic bsy);
        check_value(tag, {24'd0, bus.busy, bus.ack, bus.iso_n, bus.dom_rst_n, bus.sw_en},
                    {24'd0, bsy, ak, iso, drst, sw});
    endtask

    initial begin
        apply_stimulus(1'b0, 1'b0);
        tick(3);
        check_output("reset_state", 4'b0000, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick(20);
        check_output("off_idle_20", 4'b0000, 0, 0, 0, 0);

        $display("[TB] power-up with early SW_ACK");
        apply_stimulus(1'b1, 1'b1);
        tick(1);  check_output("pup_stage0", 4'b0001, 0, 0, 0, 1);
        tick(7);  check_output("pup_stage0_hold", 4'b0001, 0, 0, 0, 1);
        tick(1);  check_output("pup_stage1", 4'b0011, 0, 0, 0, 1);
        tick(8);  check_output("pup_stage2", 4'b0111, 0, 0, 0, 1);
        tick(8);  check_output("pup_stage3", 4'b1111, 0, 0, 0, 1);
        tick(8);  check_output("pup_wait_entry", 4'b1111, 0, 0, 0, 1);
        tick(1 + X);
        check_output("pup_dom_rst_rise", 4'b1111, 0, 1, 0, 1);
`ifdef PM_SEQ_RETENTION_EN
        check_value("pup_ret_low", {31'd0, bus.ret}, 32'd0);
`endif
        tick(1);  check_output("pup_iso_pre", 4'b1111, 0, 1, 0, 1);
        tick(1);  check_output("pup_iso_rise", 4'b1111, 1, 1, 0, 1);
        tick(1);  check_output("pup_on_pre", 4'b1111, 1, 1, 0, 1);
        tick(1);  check_output("pup_on_cycle37", 4'b1111, 1, 1, 1, 0);

        $display("[TB] power-down from ON");
        apply_stimulus(1'b0, 1'b1);
        tick(1);  check_output("pdn_iso_fall", 4'b1111, 0, 1, 1, 1);
        tick(1 + X);
        check_output("pdn_iso_hold", 4'b1111, 0, 1, 1, 1);
`ifdef PM_SEQ_RETENTION_EN
        check_value("pdn_ret_high", {31'd0, bus.ret}, 32'd1);
`endif
        tick(1);  check_output("pdn_dom_rst_fall", 4'b1111, 0, 0, 1, 1);
        tick(2);  check_output("pdn_sw_entry", 4'b1111, 0, 0, 1, 1);
        tick(7);  check_output("pdn_sw_hold", 4'b1111, 0, 0, 1, 1);
        tick(1);  check_output("pdn_stage3_off", 4'b0111, 0, 0, 1, 1);
        tick(8);  check_output("pdn_stage2_off", 4'b0011, 0, 0, 1, 1);
        tick(8);  check_output("pdn_stage1_off", 4'b0001, 0, 0, 1, 1);
        tick(7);  check_output("pdn_stage0_hold", 4'b0001, 0, 0, 1, 1);
        tick(1);  check_output("pdn_off", 4'b0000, 0, 0, 0, 0);

        $display("[TB] SW_ACK held low in PUP_WAIT");
        apply_stimulus(1'b1, 1'b0);
        tick(33); check_output("wait_entry", 4'b1111, 0, 0, 0, 1);
        tick(50); check_output("wait_hold_50", 4'b1111, 0, 0, 0, 1);
        apply_stimulus(1'b1, 1'b1);
        tick(1);
`ifdef PM_SEQ_RETENTION_EN
        check_value("pup_ret_clear", {31'd0, bus.ret}, 32'd0);
        check_output("pup_ret_state", 4'b1111, 0, 0, 0, 1);
        tick(2);
`endif
        check_output("wait_release", 4'b1111, 0, 1, 0, 1);
        tick(4);  check_output("wait_to_on", 4'b1111, 1, 1, 1, 0);

        $display("[TB] REQ dropped during PUP_SW");
        apply_stimulus(1'b0, 1'b1);
        tick(37 + X);
        check_output("drop_start_off", 4'b0000, 0, 0, 0, 0);
        apply_stimulus(1'b1, 1'b1);
        tick(3);  check_output("drop_in_pup_sw", 4'b0001, 0, 0, 0, 1);
        apply_stimulus(1'b0, 1'b1);
        tick(18); check_output("drop_pup_continues", 4'b0111, 0, 0, 0, 1);
        tick(17 + X);
        check_output("drop_reaches_on", 4'b1111, 1, 1, 1, 0);
        tick(1);  check_output("drop_pdn_starts", 4'b1111, 0, 1, 1, 1);
        tick(36 + X);
        check_output("drop_back_off", 4'b0000, 0, 0, 0, 0);

        $display("[TB] async reset mid PUP_SW");
        apply_stimulus(1'b1, 1'b1);
        tick(10); check_output("rst_pre", 4'b0011, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1 check_output("rst_async_drop", 4'b0000, 0, 0, 0, 0);
        apply_stimulus(1'b0, 1'b0);
        tick(2);  check_output("rst_held", 4'b0000, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick(5);  check_output("rst_release_off", 4'b0000, 0, 0, 0, 0);
`ifdef PM_SEQ_RETENTION_EN
        check_value("rst_ret_low", {31'd0, bus.ret}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
